// File: rtl/mapa_pkg.sv
// Shared definitions for the snake board map server: cell codes, coordinate width,
// FSM state encodings and the pending-placement slot record.
package mapa_pkg;

    localparam int COORD_W = 10;

    localparam logic [3:0] CELL_EMPTY = 4'h0;
    localparam logic [3:0] CELL_FRUTA = 4'h1;
    localparam logic [3:0] CELL_OBST  = 4'h2;
    localparam logic [3:0] CELL_COBRA = 4'h8;  // bit3 marks a snake segment, [1:0] = direction

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } slot_t;

endpackage

// File: rtl/mapa_server_if.sv
// Port bundle between the map server and its clients (update engine, placement logic, renderer).
interface mapa_server_if;
    import mapa_pkg::*;

    logic               update_renable;
    logic [COORD_W-1:0] update_rx;
    logic [COORD_W-1:0] update_ry;
    logic [3:0]         update_rdata;
    logic               update_rvalid;
    logic               update_wenable;
    logic [3:0]         update_wdata;
    logic [COORD_W-1:0] update_wx;
    logic [COORD_W-1:0] update_wy;
    logic               fruta_wenable;
    logic [COORD_W-1:0] fruta_wx;
    logic [COORD_W-1:0] fruta_wy;
    logic               obstaculo_wenable;
    logic [COORD_W-1:0] obstaculo_wx;
    logic [COORD_W-1:0] obstaculo_wy;
    logic [COORD_W-1:0] vga_rx;
    logic [COORD_W-1:0] vga_ry;
    logic [3:0]         vga_rdata;

    modport master (
        output update_renable, update_rx, update_ry,
        output update_wenable, update_wdata, update_wx, update_wy,
        output fruta_wenable, fruta_wx, fruta_wy,
        output obstaculo_wenable, obstaculo_wx, obstaculo_wy,
        output vga_rx, vga_ry,
        input  update_rdata, update_rvalid, vga_rdata
    );

    modport slave (
        input  update_renable, update_rx, update_ry,
        input  update_wenable, update_wdata, update_wx, update_wy,
        input  fruta_wenable, fruta_wx, fruta_wy,
        input  obstaculo_wenable, obstaculo_wx, obstaculo_wy,
        input  vga_rx, vga_ry,
        output update_rdata, update_rvalid, vga_rdata
    );

endinterface

// File: rtl/mapa_ram_2r1w.sv
// Board storage: one write port, two registered read-first read ports.
module mapa_ram_2r1w #(
    parameter int DEPTH = 1200,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [3:0]    rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [3:0]    rdata_b
);

    logic [3:0] mem [DEPTH];

    // Reads sample the array before this edge's write lands, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_a <= mem[raddr_a];
        rdata_b <= mem[raddr_b];
    end

endmodule

// File: rtl/mapa_server.sv
// Snake board map server: clear sweep FSM, write arbitration with pending fruit/obstacle
// slots, range checking and the update/renderer read ports.
module mapa_server
    import mapa_pkg::*;
#(
    parameter int MAPA_HEIGHT = 30,
    parameter int MAPA_WIDTH  = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_req,
    output logic         busy,
    output logic         write_drop,
    mapa_server_if.slave bus
);

    localparam int          DEPTH = MAPA_HEIGHT * MAPA_WIDTH;
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] W_U   = MAPA_WIDTH;
    localparam logic [31:0] H_U   = MAPA_HEIGHT;

    function automatic logic in_range(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return (32'(x) < W_U) && (32'(y) < H_U);
    endfunction

    function automatic logic [AW-1:0] to_addr(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return AW'(32'(y) * W_U + 32'(x));
    endfunction

    logic [0:0]    state;
    logic [AW-1:0] sweep;
    slot_t         fruta_q, obst_q, fruta_cand, obst_cand;
    logic          upd_w_ok, fruta_new, obst_new, fruta_grant, obst_grant;
    logic          we;
    logic [AW-1:0] waddr, upd_raddr, vga_raddr;
    logic [3:0]    wdata, upd_ram, vga_ram;
    logic          upd_oob, vga_oob;
    logic          upd_clr_q, upd_oob_q, upd_rvalid_q, vga_clr_q, vga_oob_q;

    assign upd_w_ok  = bus.update_wenable && in_range(bus.update_wx, bus.update_wy);
    assign fruta_new = bus.fruta_wenable && in_range(bus.fruta_wx, bus.fruta_wy);
    assign obst_new  = bus.obstaculo_wenable && in_range(bus.obstaculo_wx, bus.obstaculo_wy);

    // A fresh strobe supersedes whatever its slot holds; it can be written this very cycle.
    assign fruta_cand = fruta_new ? '{1'b1, bus.fruta_wx, bus.fruta_wy} : fruta_q;
    assign obst_cand  = obst_new ? '{1'b1, bus.obstaculo_wx, bus.obstaculo_wy} : obst_q;

    always_comb begin
        we          = 1'b0;
        waddr       = '0;
        wdata       = CELL_EMPTY;
        fruta_grant = 1'b0;
        obst_grant  = 1'b0;
        if (state == ST_CLEAR) begin
            we    = 1'b1;
            waddr = sweep;
        end else if (upd_w_ok) begin
            we    = 1'b1;
            waddr = to_addr(bus.update_wx, bus.update_wy);
            wdata = bus.update_wdata;
        end else if (obst_cand.valid) begin
            we         = 1'b1;
            waddr      = to_addr(obst_cand.x, obst_cand.y);
            wdata      = CELL_OBST;
            obst_grant = 1'b1;
        end else if (fruta_cand.valid) begin
            we          = 1'b1;
            waddr       = to_addr(fruta_cand.x, fruta_cand.y);
            wdata       = CELL_FRUTA;
            fruta_grant = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_CLEAR;
            sweep      <= '0;
            fruta_q    <= '0;
            obst_q     <= '0;
            write_drop <= 1'b0;
        end else begin
            write_drop <= 1'b0;
            if (state == ST_CLEAR) begin
                if (sweep == AW'(DEPTH - 1)) begin
                    state <= ST_RUN;
                    sweep <= '0;
                end else begin
                    sweep <= sweep + 1'b1;
                end
            end else if (clear_req) begin
                state   <= ST_CLEAR;
                sweep   <= '0;
                fruta_q <= '0;
                obst_q  <= '0;
            end else begin
                fruta_q    <= fruta_grant ? '0 : fruta_cand;
                obst_q     <= obst_grant ? '0 : obst_cand;
                write_drop <= (fruta_new && fruta_q.valid) || (obst_new && obst_q.valid);
            end
        end
    end

    assign busy = (state == ST_CLEAR);

    // Out-of-range reads park the RAM address at 0; the registered flags override the data.
    assign upd_oob   = !in_range(bus.update_rx, bus.update_ry);
    assign vga_oob   = !in_range(bus.vga_rx, bus.vga_ry);
    assign upd_raddr = upd_oob ? '0 : to_addr(bus.update_rx, bus.update_ry);
    assign vga_raddr = vga_oob ? '0 : to_addr(bus.vga_rx, bus.vga_ry);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            upd_rvalid_q <= 1'b0;
            upd_clr_q    <= 1'b1;
            upd_oob_q    <= 1'b0;
            vga_clr_q    <= 1'b1;
            vga_oob_q    <= 1'b0;
        end else begin
            upd_rvalid_q <= bus.update_renable;
            upd_clr_q    <= (state == ST_CLEAR);
            upd_oob_q    <= upd_oob;
            vga_clr_q    <= (state == ST_CLEAR);
            vga_oob_q    <= vga_oob;
        end
    end

    assign bus.update_rvalid = upd_rvalid_q;
    assign bus.update_rdata  = upd_clr_q ? CELL_EMPTY : (upd_oob_q ? CELL_OBST : upd_ram);
    assign bus.vga_rdata     = vga_clr_q ? CELL_EMPTY : (vga_oob_q ? CELL_OBST : vga_ram);

    mapa_ram_2r1w #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (upd_raddr),
        .rdata_a (upd_ram),
        .raddr_b (vga_raddr),
        .rdata_b (vga_ram)
    );

endmodule
